rmii_ether_rx: RTL



---
 rtl/rmii_ether_rx_if.sv | 28 ++
 rtl/rmii_ether_rx.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/rmii_ether_rx_if.sv
// RMII receive bundle: raw carrier/dibit inputs plus the framed dibit stream
// and the per-frame status pulses.
interface rmii_ether_rx_if;
    logic       crsdv;
    logic [1:0] rxd;
    logic [1:0] axiod;
    logic       axiov;
    logic       frame_err;
    logic       frame_done;

    modport slave (
        input  crsdv,
        input  rxd,
        output axiod,
        output axiov,
        output frame_err,
        output frame_done
    );

    modport master (
        output crsdv,
        output rxd,
        input  axiod,
        input  axiov,
        input  frame_err,
        input  frame_done
    );
endinterface

// File: rtl/rmii_ether_rx.sv
// RMII receive framer: strips preamble/SFD, forwards the frame body as a
// dibit stream, and flags bad preambles, lost carrier and jabber.
module rmii_ether_rx #(
    parameter int unsigned MIN_PRE    = 16,
    parameter int unsigned MAX_DIBITS = 6100
) (
    input  logic           clk,
    input  logic           rst_n,
    rmii_ether_rx_if.slave bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] PRE  = 2'd1;
    localparam logic [1:0] DATA = 2'd2;
    localparam logic [1:0] DROP = 2'd3;

    localparam logic [4:0]  PRE_MIN = 5'(MIN_PRE);
    localparam logic [12:0] DIB_MAX = 13'(MAX_DIBITS);
    localparam logic [4:0]  PRE_SAT = 5'd31;

    logic [1:0]  state, state_nx;
    logic [4:0]  pre_cnt, pre_cnt_nx;
    logic [12:0] dib_cnt, dib_cnt_nx;
    logic        armed, armed_nx;

    logic        crsdv_q;
    logic [1:0]  rxd_q;
    logic        q_valid;

    logic        fwd;
    logic        err_nx;
    logic        done_nx;

    // Input capture stage; q_valid marks that crsdv_q holds a real sample
    // rather than its reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crsdv_q <= 1'b0;
            rxd_q   <= '0;
            q_valid <= 1'b0;
        end else begin
            crsdv_q <= bus.crsdv;
            rxd_q   <= bus.rxd;
            q_valid <= 1'b1;
        end
    end

    // armed stays low after reset until a carrier-off sample is seen, so a
    // frame already in flight at reset release is discarded like DROP.
    always_comb begin
        state_nx   = state;
        pre_cnt_nx = pre_cnt;
        dib_cnt_nx = dib_cnt;
        armed_nx   = armed;
        fwd        = 1'b0;
        err_nx     = 1'b0;
        done_nx    = 1'b0;
        if (q_valid) begin
            if (!crsdv_q) begin
                armed_nx = 1'b1;
            end
            case (state)
                IDLE: begin
                    if (crsdv_q) begin
                        if (!armed) begin
                            state_nx = DROP;
                        end else if (rxd_q == 2'b01) begin
                            state_nx   = PRE;
                            pre_cnt_nx = 5'd1;
                        end else if (rxd_q[1]) begin
                            state_nx = DROP;
                        end
                    end
                end
                PRE: begin
                    if (!crsdv_q) begin
                        state_nx = IDLE;
                        err_nx   = 1'b1;
                    end else begin
                        case (rxd_q)
                            2'b01: begin
                                if (pre_cnt != PRE_SAT) begin
                                    pre_cnt_nx = pre_cnt + 5'd1;
                                end
                            end
                            2'b11: begin
                                if (pre_cnt >= PRE_MIN) begin
                                    state_nx   = DATA;
                                    dib_cnt_nx = '0;
                                end else begin
                                    state_nx = DROP;
                                    err_nx   = 1'b1;
                                end
                            end
                            default: begin
                                state_nx = DROP;
                                err_nx   = 1'b1;
                            end
                        endcase
                    end
                end
                DATA: begin
                    if (!crsdv_q) begin
                        state_nx = IDLE;
                        done_nx  = 1'b1;
                    end else if (dib_cnt < DIB_MAX) begin
                        fwd        = 1'b1;
                        dib_cnt_nx = dib_cnt + 13'd1;
                    end else begin
                        state_nx = DROP;
                        err_nx   = 1'b1;
                    end
                end
                default: begin
                    if (!crsdv_q) begin
                        state_nx = IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pre_cnt <= '0;
            dib_cnt <= '0;
            armed   <= 1'b0;
        end else begin
            state   <= state_nx;
            pre_cnt <= pre_cnt_nx;
            dib_cnt <= dib_cnt_nx;
            armed   <= armed_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.axiov      <= 1'b0;
            bus.axiod      <= '0;
            bus.frame_err  <= 1'b0;
            bus.frame_done <= 1'b0;
        end else begin
            bus.axiov      <= fwd;
            bus.axiod      <= fwd ? rxd_q : 2'b00;
            bus.frame_err  <= err_nx;
            bus.frame_done <= done_nx;
        end
    end

endmodule
